// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the multicycle RV32I control sequencer:
//   - state_e     : 4-bit sequencer state encoding
//   - OP_*        : RV32I major opcodes recognised by the sequencer
//   - ALUOP_*, RES_*, SRCA_*, SRCB_*, IMM_* : datapath select encodings
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_JALR2    = 4'd11,
    S_BEQ      = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm_imm_src_decoder.sv
// ---------------------------------------------------------------------------
// imm_src_decoder
// Pure combinational map from the instruction opcode to the immediate
// format select used by the immediate extender.
// Ports:
//   op      in  [6:0]  opcode field of the instruction register
//   imm_src out [1:0]  00 = I, 01 = S, 10 = B, 11 = J
// ---------------------------------------------------------------------------
module imm_src_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  // Opcode to immediate format; loads, I-ALU, jalr and unknown use I-type
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Moore control sequencer for the multicycle RV32I core. A single ALU and a
// unified memory are shared across FETCH / DECODE / EXECUTE / MEM / WB steps;
// this block drives all datapath selects and write enables from its state,
// with memory states stalled by the mem_ready handshake.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   op               opcode from the instruction register
//   zero             ALU zero flag (branch resolution)
//   mem_ready        memory access completes this cycle
//   mem_req          memory access requested this cycle
//   PCWrite          PC enable (PCUpdate | Branch & zero)
//   AdrSrc           memory address select: 0 = PC, 1 = ALUOut
//   MemWrite         data store enable
//   IRWrite          instruction register / OldPC enable
//   RegWrite         register file write enable
//   ResultSrc        00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA          00 = PC, 01 = OldPC, 10 = rs1
//   ALUSrcB          00 = rs2, 01 = Imm, 10 = const 4
//   ALUOp            00 = add, 01 = sub/branch, 10 = funct-decoded
//   ImmSrc           00 = I, 01 = S, 10 = B, 11 = J
//   illegal_op       one-cycle pulse in DECODE on an unsupported opcode
// ---------------------------------------------------------------------------
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int OP_W          = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            PCWrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ImmSrc,
  output logic            illegal_op
);

  state_e state_q;
  state_e state_d;
  state_e cur_state;
  logic   rdy;
  logic   pc_update;
  logic   branch;

  // Without the handshake every memory access completes in one cycle
  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // While in reset the outputs present FETCH selects regardless of the
  // stale state register, so the datapath muxes are well defined.
  assign cur_state = rst ? S_FETCH : state_q;

  imm_src_decoder u_imm_src_decoder (
    .op      (op[6:0]),
    .imm_src (ImmSrc)
  );

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode, gated by rdy in memory states
  always_comb begin
    state_d    = S_FETCH;
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALUOP_ADD;
    illegal_op = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    PCWrite    = 1'b0;

    case (cur_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = rdy;
        pc_update = rdy;
        if (rdy) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute OldPC + Imm into ALUOut for branch/jal targets
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op[6:0])
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECUTER;
          OP_I:              state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BEQ;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (op[6:0] == OP_LOAD) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (rdy) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = rdy;
        if (rdy) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        // PC <- ALUOut (target), ALU computes OldPC + 4 for the link
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = S_JALR2;
      end
      S_JALR2: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        // Unreachable encodings: all enables stay at their 0 defaults
        state_d = S_FETCH;
      end
    endcase

    PCWrite = pc_update | (branch & zero);

    // No write enable or request may leak out during a reset cycle
    if (rst) begin
      state_d    = S_FETCH;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      mem_req    = 1'b0;
      illegal_op = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Builds, per instruction, the expected cycle-by-cycle output trace from the
// instruction's step list and its chosen wait counts, then replays it against
// the DUT. Directed cases come first, then randomized instructions.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       mreq;
    logic       ill;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

  int tests = 0;
  int fails = 0;

  exp_t exq[$];
  bit   rdq[$];
  bit   zq[$];

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1), .OP_W(7)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic exp_t e(input logic pcw, input logic adr, input logic mw,
                             input logic irw, input logic rw, input logic mreq,
                             input logic ill, input logic [1:0] rs,
                             input logic [1:0] sa, input logic [1:0] sb,
                             input logic [1:0] aop);
    exp_t x;
    x = '{pcw, adr, mw, irw, rw, mreq, ill, rs, sa, sb, aop};
    return x;
  endfunction

  function automatic bit rz();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit known(input logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
           (o == 7'b0010011) || (o == 7'b1101111) || (o == 7'b1100111) ||
           (o == 7'b1100011);
  endfunction

  function automatic logic [1:0] imm_exp(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  task automatic push(input exp_t x, input bit r, input bit z);
    exq.push_back(x);
    rdq.push_back(r);
    zq.push_back(z);
  endtask

  // Expected trace of one instruction: wf fetch waits, wm memory waits,
  // z drives the zero flag in the branch-resolve cycle (random elsewhere).
  task automatic build(input logic [6:0] o, input int wf, input int wm, input bit z);
    exp_t f_step  = e(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00);
    exp_t madr    = e(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00);
    exp_t mem_acc = e(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00);
    exp_t aluwb   = e(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00);
    exp_t linkpc  = e(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00);
    for (int i = 0; i < wf; i++) push(f_step, 1'b0, rz());
    push(e(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00), 1'b1, rz());
    push(e(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,!known(o),2'b00,2'b01,2'b01,2'b00), rz(), rz());
    case (o)
      7'b0000011: begin
        push(madr, rz(), rz());
        for (int i = 0; i < wm; i++) push(mem_acc, 1'b0, rz());
        push(mem_acc, 1'b1, rz());
        push(e(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,2'b00,2'b00,2'b00), rz(), rz());
      end
      7'b0100011: begin
        push(madr, rz(), rz());
        for (int i = 0; i < wm; i++) push(mem_acc, 1'b0, rz());
        push(e(1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00), 1'b1, rz());
      end
      7'b0110011: begin
        push(e(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10), rz(), rz());
        push(aluwb, rz(), rz());
      end
      7'b0010011: begin
        push(e(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10), rz(), rz());
        push(aluwb, rz(), rz());
      end
      7'b1101111: begin
        push(linkpc, rz(), rz());
        push(aluwb, rz(), rz());
      end
      7'b1100111: begin
        push(madr, rz(), rz());
        push(linkpc, rz(), rz());
        push(aluwb, rz(), rz());
      end
      7'b1100011: begin
        push(e(z,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01), rz(), z);
      end
      default: begin
      end
    endcase
  endtask

  task automatic check_cycle(input string tag, input int n, input exp_t ex);
    exp_t obs;
    obs = '{PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mem_req, illegal_op,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
    tests++;
    assert (obs === ex) else begin
      fails++;
      $error("FAIL %s cyc%0d outputs observed=%b expected=%b", tag, n, obs, ex);
    end
    tests++;
    assert (ImmSrc === imm_exp(op)) else begin
      fails++;
      $error("FAIL %s cyc%0d ImmSrc observed=%b expected=%b", tag, n, ImmSrc, imm_exp(op));
    end
  endtask

  // Replays the queued trace; called just after an active edge
  task automatic run(input string tag, input logic [6:0] o);
    int n = 0;
    op = o;
    while (exq.size() > 0) begin
      exp_t ex;
      ex        = exq.pop_front();
      mem_ready = rdq.pop_front();
      zero      = zq.pop_front();
      @(negedge clk);
      check_cycle(tag, n, ex);
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t rst_exp;
    logic [6:0] ops [0:6];
    rst_exp = e(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00);
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1101111; ops[5] = 7'b1100111;
    ops[6] = 7'b1100011;

    rst = 1'b1; op = 7'b0110011; zero = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_cycle("reset", i, rst_exp);
      @(posedge clk);
    end
    #1 rst = 1'b0;

    build(7'b0110011, 0, 0, 1'b0); run("add", 7'b0110011);
    build(7'b0000011, 2, 1, 1'b0); run("lw_wait", 7'b0000011);
    build(7'b0100011, 0, 3, 1'b0); run("sw_wait", 7'b0100011);
    build(7'b1100011, 0, 0, 1'b1); run("beq_taken", 7'b1100011);
    build(7'b1100011, 0, 0, 1'b0); run("beq_not", 7'b1100011);
    build(7'b1101111, 0, 0, 1'b0); run("jal", 7'b1101111);
    build(7'b1100111, 0, 0, 1'b0); run("jalr", 7'b1100111);
    build(7'b1111111, 0, 0, 1'b0); run("illegal", 7'b1111111);

    // Reset landing on the ready MEMWRITE cycle: store must be suppressed
    build(7'b0100011, 1, 0, 1'b0);
    void'(exq.pop_back()); void'(rdq.pop_back()); void'(zq.pop_back());
    run("sw_pre_rst", 7'b0100011);
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check_cycle("rst_in_memwrite", 0, rst_exp);
    @(posedge clk);
    #1 rst = 1'b0;
    build(7'b0010011, 0, 0, 1'b0); run("addi_after_rst", 7'b0010011);

    for (int k = 0; k < 60; k++) begin
      logic [6:0] o;
      int sel;
      sel = int'($urandom_range(0, 8));
      if (sel < 7) o = ops[sel];
      else if (sel == 7) o = 7'b1111111;
      else o = 7'($urandom_range(0, 127));
      build(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rz());
      run("random", o);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control sequencer for the multicycle RV32I core. One shared ALU and one unified instruction/data memory are time-multiplexed across FETCH, DECODE, EXECUTE, MEM and WB steps.
- Drives the datapath mux selects and write enables from a Moore state machine, gated by the memory ready handshake.
- Sits between the instruction register opcode field and the datapath; the existing ALU decoder consumes its ALUOp.

Parameters:
- MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready. 0: mem_ready is ignored and treated as 1.
- OP_W, 7, opcode width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  opcode from instruction register (instr[6:0])
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access requested this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data store enable
- IRWrite  out  1  instruction register / OldPC enable
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = Imm, 10 = const 4
- ALUOp  out  2  00 = add, 01 = sub/branch, 10 = funct-decoded
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Reset: state <= FETCH on any clk edge with rst = 1. While rst = 1, force PCWrite, IRWrite, RegWrite, MemWrite, mem_req and illegal_op to 0. Muxes and ALUOp hold FETCH values.
- Outputs are combinational from state. The only exceptions are the mem_ready gating and PCWrite.
- Unlisted outputs are 0 in every state.
- State outputs and transitions (rdy = mem_ready, or 1 when MEM_HANDSHAKE = 0):
  - FETCH: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10. IRWrite = rdy, PCUpdate = rdy. Stay while !rdy; DECODE on rdy.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch/jal target to ALUOut). Next state by op:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 1100011 -> BEQ
    - other -> FETCH with illegal_op = 1
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Next MEMREAD if op = lw, else MEMWRITE.
  - MEMREAD: mem_req = 1, AdrSrc = 1, ResultSrc = 00. Stay while !rdy, then MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite = 1. Next FETCH.
  - MEMWRITE: mem_req = 1, AdrSrc = 1, ResultSrc = 00, MemWrite = rdy. Stay while !rdy, then FETCH.
  - EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Next ALUWB.
  - EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Next ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite = 1. Next FETCH.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1. Next ALUWB.
  - JALR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Next JALR2.
  - JALR2: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1. Next ALUWB.
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1. Next FETCH.
- PCWrite = PCUpdate | (Branch & zero). PCUpdate and Branch are internal.
- ImmSrc is combinational from op in every state:
  - lw / I-ALU / jalr = 00
  - sw = 01
  - beq = 10
  - jal = 11
  - unknown = 00
- op is sampled only in DECODE and MEMADR. The IR is stable there because IRWrite = 0 outside FETCH.
- Cycle counts with zero wait states:
  - lw: 5
  - sw: 4
  - R-type / I-type: 4
  - jal: 4
  - jalr: 5
  - beq: 3
  - illegal: 2
  - Each wait cycle adds 1 in FETCH, MEMREAD or MEMWRITE.
- mem_ready outside the memory states is ignored. MemWrite and IRWrite never assert without rdy.
- rst mid-instruction: next state is FETCH regardless of the current state. No write enable asserts in the reset cycle.
- Unreachable state encodings return to FETCH with all enables 0.

Decomposition:
- Shared package rv_ctrl_pkg:
  - state enum, 4-bit encoding
  - opcode constants: OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR, OP_BRANCH
  - ALUOp, ResultSrc, ALUSrcA/B and ImmSrc encodings
- One sub-module, imm_src_decoder (op -> ImmSrc). The FSM next-state and output logic stay in the top module.

Test Plan:
- rst = 1 for 2 cycles, then op = 0110011 (add), mem_ready = 1 -> states FETCH, DECODE, EXECUTER, ALUWB. RegWrite = 1 only in cycle 4, with ALUOp = 10 in cycle 3.
- lw (op = 0000011), mem_ready low 2 cycles in FETCH and 1 cycle in MEMREAD -> 8 cycles total. IRWrite and PCWrite pulse once, in the ready FETCH cycle. MEMWB has ResultSrc = 01, RegWrite = 1.
- sw (op = 0100011) with mem_ready = 0 for 3 cycles in MEMWRITE -> MemWrite = 0 for those 3 cycles, then exactly one cycle with MemWrite = 1, AdrSrc = 1, then FETCH. RegWrite never asserts.
- beq with zero = 1 -> PCWrite = 1 in BEQ with ALUOp = 01. Repeat with zero = 0 -> PCWrite = 0. Both return to FETCH after 3 cycles.
- jal then jalr -> jal: PCWrite in JAL, then ALUWB RegWrite, ImmSrc = 11. jalr: JALR then JALR2 PCWrite = 1, then ALUWB, ImmSrc = 00.
- op = 1111111 -> illegal_op = 1 for exactly one cycle in DECODE, then FETCH, no RegWrite or MemWrite. Separately, rst asserted during MEMWRITE with mem_ready = 1 -> MemWrite = 0 that cycle and the next state is FETCH.
